sram_stream_adapter: RTL and testbench

Upstream request/response adapter for the single-ported SRAM macro wrapper. It converts a valid/ready request stream into the SRAM's req/we/addr/wdata/be pin interface. It also tracks the fixed SRAM read latency (1 without output registers, 2 with) and captures read data into a small response FIFO with valid/ready back-pressure, so consumers never lose read data while stalling. It sits between a core/DMA-side requester and the SRAM wrapper, with its SRAM-side ports wired one-to-one to the macro.

---
 rtl/sram_stream_adapter.sv | 152 +++++++++++++++
 tb/tb_sram_stream_adapter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_stream_adapter.sv
// sram_stream_adapter
// Bridges a valid/ready request stream onto a single-ported SRAM pin
// interface and returns read data through a small response FIFO. A credit
// counter limits accepted reads to what the FIFO can hold, so read data
// returning from the SRAM is never dropped while the consumer stalls.
//
// Ports
//   clk_i, rst_i               clock, synchronous active-high reset
//   req_valid_i / req_ready_o  request handshake (req_ready_o has no path from rsp side)
//   req_we_i, req_addr_i       1 = write / 0 = read, word address
//   req_wdata_i, req_be_i      write data and byte enables
//   rsp_valid_o / rsp_ready_i  read response handshake
//   rsp_rdata_o                read data (head of response FIFO)
//   sram_req_o .. sram_be_o    SRAM macro request pins (pass-through)
//   sram_rdata_i               SRAM read data, valid Latency cycles after a read
module sram_stream_adapter #(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned Latency   = 1,
    parameter int unsigned RspDepth  = 2,
    localparam int unsigned AddrWidth = $clog2(NumWords),
    localparam int unsigned BeWidth   = (DataWidth + 7) / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [DataWidth-1:0] req_wdata_i,
    input  logic [BeWidth-1:0]   req_be_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_o,
    output logic                 sram_req_o,
    output logic                 sram_we_o,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0] sram_wdata_o,
    output logic [BeWidth-1:0]   sram_be_o,
    input  logic [DataWidth-1:0] sram_rdata_i
);

    localparam int unsigned CntWidth = $clog2(RspDepth + 1);
    localparam int unsigned PtrWidth = (RspDepth > 1) ? $clog2(RspDepth) : 1;

    // Reject illegal configurations at elaboration
    if (Latency < 1 || Latency > 2) begin : g_bad_latency
        $error("sram_stream_adapter: Latency must be 1 or 2");
    end
    if (RspDepth < 1) begin : g_bad_depth
        $error("sram_stream_adapter: RspDepth must be >= 1");
    end
    if (NumWords < 2) begin : g_bad_words
        $error("sram_stream_adapter: NumWords must be >= 2");
    end
    if (DataWidth < 1) begin : g_bad_width
        $error("sram_stream_adapter: DataWidth must be >= 1");
    end

    logic [CntWidth-1:0]  cnt_q;
    logic [Latency-1:0]   tag_q;
    logic [PtrWidth-1:0]  wr_ptr_q;
    logic [PtrWidth-1:0]  rd_ptr_q;
    logic [CntWidth-1:0]  count_q;
    logic [DataWidth-1:0] mem_q [RspDepth];

    logic accept;
    logic rd_accept;
    logic push;
    logic pop;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(RspDepth - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    // Request side: credit check only, nothing from the response handshake
    assign req_ready_o = !rst_i && (cnt_q < CntWidth'(RspDepth));
    assign accept      = req_valid_i && req_ready_o;
    assign rd_accept   = accept && !req_we_i;

    // SRAM pins
    assign sram_req_o   = accept;
    assign sram_we_o    = req_we_i;
    assign sram_addr_o  = req_addr_i;
    assign sram_wdata_o = req_wdata_i;
    assign sram_be_o    = req_be_i;

    // Response side
    assign push        = tag_q[Latency-1];
    assign rsp_valid_o = !rst_i && (count_q != '0);
    assign pop         = rsp_valid_o && rsp_ready_i;
    assign rsp_rdata_o = mem_q[rd_ptr_q];

    // Credits: reads in flight plus buffered responses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (rd_accept && !pop) begin
            cnt_q <= cnt_q + CntWidth'(1);
        end else if (!rd_accept && pop) begin
            cnt_q <= cnt_q - CntWidth'(1);
        end
    end

    // Read tags track the fixed SRAM latency
    if (Latency == 1) begin : g_tag_single
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                tag_q <= '0;
            end else begin
                tag_q <= rd_accept;
            end
        end
    end else begin : g_tag_shift
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                tag_q <= '0;
            end else begin
                tag_q <= {tag_q[Latency-2:0], rd_accept};
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_q <= count_q + CntWidth'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CntWidth'(1);
            end
        end
    end

    // FIFO storage; no reset needed, validity comes from count_q
    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            mem_q[wr_ptr_q] <= sram_rdata_i;
        end
    end

endmodule

// File: tb/tb_sram_stream_adapter.sv
module tb_sram_stream_adapter;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [9:0]  req_addr  [2];
    logic [63:0] req_wdata [2];
    logic [7:0]  req_be    [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [63:0] rsp_rdata [2];
    logic        sram_req  [2];
    logic        sram_we   [2];
    logic [9:0]  sram_addr [2];
    logic [63:0] sram_wdata[2];
    logic [7:0]  sram_be   [2];
    logic [63:0] sram_rdata[2];

    int total = 0;
    int bad   = 0;

    // Reference model: word memory per instance plus queue of expected read data
    logic [63:0] ref_mem [2][1024];
    logic [63:0] exp_dat [2][256];
    int          exp_head[2];
    int          exp_tail[2];
    logic        hold    [2];
    logic [63:0] hold_dat[2];

    // Response log for timing checks
    int          pop_n  [2];
    int          pop_cyc[2][64];
    logic [63:0] pop_dat[2][64];

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] init_word(input int a);
        return {32'hC0DE_0000 + 32'(a), ~32'(a) ^ 32'h5A5A_5A5A};
    endfunction

    function automatic int dep(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Instance 0: Latency=1 RspDepth=2; instance 1: Latency=2 RspDepth=3
    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int unsigned LAT = (g == 0) ? 1 : 2;
        localparam int unsigned DPT = (g == 0) ? 2 : 3;

        logic [63:0] mem [1024];
        logic [63:0] d1;
        logic [63:0] d2;

        initial for (int a = 0; a < 1024; a++) mem[a] = init_word(a);

        // Behavioural SRAM macro
        always @(posedge clk) begin
            if (sram_req[g]) begin
                if (sram_we[g]) begin
                    for (int b = 0; b < 8; b++)
                        if (sram_be[g][b]) mem[sram_addr[g]][8*b +: 8] <= sram_wdata[g][8*b +: 8];
                end else begin
                    d1 <= mem[sram_addr[g]];
                end
            end
            d2 <= d1;
        end
        assign sram_rdata[g] = (LAT == 1) ? d1 : d2;

        sram_stream_adapter #(
            .DataWidth(64), .NumWords(1024), .Latency(LAT), .RspDepth(DPT)
        ) dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .req_valid_i (req_valid[g]),
            .req_ready_o (req_ready[g]),
            .req_we_i    (req_we[g]),
            .req_addr_i  (req_addr[g]),
            .req_wdata_i (req_wdata[g]),
            .req_be_i    (req_be[g]),
            .rsp_valid_o (rsp_valid[g]),
            .rsp_ready_i (rsp_ready[g]),
            .rsp_rdata_o (rsp_rdata[g]),
            .sram_req_o  (sram_req[g]),
            .sram_we_o   (sram_we[g]),
            .sram_addr_o (sram_addr[g]),
            .sram_wdata_o(sram_wdata[g]),
            .sram_be_o   (sram_be[g]),
            .sram_rdata_i(sram_rdata[g])
        );
    end

    // Scoreboard, sampled mid-cycle
    always @(negedge clk) begin : monitor
        int occ;
        for (int i = 0; i < 2; i++) begin
            occ = exp_tail[i] - exp_head[i];
            if (rst) begin
                chk("rst_req_ready", 64'(req_ready[i]), 64'd0);
                chk("rst_rsp_valid", 64'(rsp_valid[i]), 64'd0);
                chk("rst_sram_req", 64'(sram_req[i]), 64'd0);
                exp_head[i] = exp_tail[i];
                hold[i] = 1'b0;
            end else begin
                chk("credit_ready", 64'(req_ready[i]), 64'(occ < dep(i)));
                chk("sram_req", 64'(sram_req[i]), 64'(req_valid[i] && (occ < dep(i))));
                if (sram_req[i])
                    chk("sram_pins", {sram_we[i], sram_addr[i], sram_be[i], 45'd0} ^ sram_wdata[i],
                        {req_we[i], req_addr[i], req_be[i], 45'd0} ^ req_wdata[i]);
                if (hold[i]) begin
                    chk("hold_valid", 64'(rsp_valid[i]), 64'd1);
                    chk("hold_data", rsp_rdata[i], hold_dat[i]);
                end
                if (rsp_valid[i] && rsp_ready[i]) begin
                    if (occ == 0) begin
                        chk("rsp_unexpected", 64'(rsp_valid[i]), 64'd0);
                    end else begin
                        chk("rsp_data", rsp_rdata[i], exp_dat[i][exp_head[i] % 256]);
                        exp_head[i]++;
                    end
                    if (pop_n[i] < 64) begin
                        pop_cyc[i][pop_n[i]] = cyc;
                        pop_dat[i][pop_n[i]] = rsp_rdata[i];
                    end
                    pop_n[i]++;
                end
                hold[i] = rsp_valid[i] && !rsp_ready[i];
                hold_dat[i] = rsp_rdata[i];
                if (req_valid[i] && req_ready[i]) begin
                    if (req_we[i]) begin
                        for (int b = 0; b < 8; b++)
                            if (req_be[i][b])
                                ref_mem[i][req_addr[i]][8*b +: 8] = req_wdata[i][8*b +: 8];
                    end else begin
                        exp_dat[i][exp_tail[i] % 256] = ref_mem[i][req_addr[i]];
                        exp_tail[i]++;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) step();
    endtask

    // Hold a request until accepted; returns acceptance cycle
    task automatic send(input int i, input logic we, input logic [9:0] a,
                        input logic [63:0] d, input logic [7:0] be, output int t);
        bit done;
        done = 1'b0;
        t = -1;
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i]  = a;
        req_wdata[i] = d;
        req_be[i]    = be;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                done = 1'b1;
                t = cyc;
            end
            step();
        end
        req_valid[i] = 1'b0;
        chk("send_accepted", 64'(done), 64'd1);
    endtask

    initial begin
        int t0, t1, t2, t3;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0;
            req_wdata[i] = '0;   req_be[i] = '0;   rsp_ready[i] = 1'b1;
            exp_head[i] = 0; exp_tail[i] = 0; hold[i] = 1'b0; pop_n[i] = 0;
            for (int a = 0; a < 1024; a++) ref_mem[i][a] = init_word(a);
        end
        wait_cycles(3);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_ready0", 64'(req_ready[0]), 64'd1);
        chk("post_reset_ready1", 64'(req_ready[1]), 64'd1);
        chk("post_reset_valid0", 64'(rsp_valid[0]), 64'd0);
        step();

        // Write then read-after-write, Latency=1
        pop_n[0] = 0;
        send(0, 1'b1, 10'd5, 64'hDEADBEEF_CAFEF00D, 8'hFF, t0);
        send(0, 1'b0, 10'd5, 64'd0, 8'h00, t1);
        chk("raw_back_to_back", 64'(t1), 64'(t0 + 1));
        wait_cycles(6);
        chk("raw_rsp_count", 64'(pop_n[0]), 64'd1);
        chk("raw_rsp_cycle", 64'(pop_cyc[0][0]), 64'(t1 + 2));
        chk("raw_rsp_data", pop_dat[0][0], 64'hDEADBEEF_CAFEF00D);

        // Partial byte-enable write
        pop_n[0] = 0;
        send(0, 1'b1, 10'd9, 64'hAAAAAAAA_BBBBBBBB, 8'hFF, t0);
        send(0, 1'b1, 10'd9, 64'h11111111_22222222, 8'h0F, t0);
        send(0, 1'b0, 10'd9, 64'd0, 8'h00, t0);
        wait_cycles(6);
        chk("be_rsp_count", 64'(pop_n[0]), 64'd1);
        chk("be_rsp_data", pop_dat[0][0], 64'hAAAAAAAA_22222222);

        // Full FIFO with simultaneous pop and request
        pop_n[0] = 0;
        rsp_ready[0] = 1'b0;
        send(0, 1'b0, 10'd1, 64'd0, 8'h00, t0);
        send(0, 1'b0, 10'd2, 64'd0, 8'h00, t0);
        wait_cycles(3);
        @(negedge clk);
        chk("full_ready_low", 64'(req_ready[0]), 64'd0);
        chk("full_rsp_valid", 64'(rsp_valid[0]), 64'd1);
        step();
        rsp_ready[0] = 1'b1;
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 10'd3;
        @(negedge clk);
        chk("full_same_cycle_blocked", 64'(req_ready[0]), 64'd0);
        step();
        @(negedge clk);
        chk("full_next_cycle_ready", 64'(req_ready[0]), 64'd1);
        t3 = cyc;
        step();
        req_valid[0] = 1'b0;
        wait_cycles(6);
        chk("full_rsp_count", 64'(pop_n[0]), 64'd3);
        chk("full_first_pop_cycle", 64'(pop_cyc[0][0]), 64'(t3 - 1));
        chk("full_rsp0", pop_dat[0][0], init_word(1));
        chk("full_rsp2", pop_dat[0][2], init_word(3));

        // Back-pressure, Latency=2 RspDepth=3
        pop_n[1] = 0;
        rsp_ready[1] = 1'b0;
        for (int a = 0; a < 3; a++) send(1, 1'b0, 10'(a), 64'd0, 8'h00, t0);
        @(negedge clk);
        chk("bp_ready_drop", 64'(req_ready[1]), 64'd0);
        step();
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 10'd3;
        repeat (4) begin
            @(negedge clk);
            chk("bp_ready_held_low", 64'(req_ready[1]), 64'd0);
            step();
        end
        rsp_ready[1] = 1'b1;
        send(1, 1'b0, 10'd3, 64'd0, 8'h00, t0);
        send(1, 1'b0, 10'd4, 64'd0, 8'h00, t0);
        wait_cycles(8);
        chk("bp_rsp_count", 64'(pop_n[1]), 64'd5);
        for (int k = 0; k < 5; k++) chk("bp_rsp_order", pop_dat[1][k], init_word(k));

        // Streaming reads: each response exactly Latency+1 after its accept
        begin
            int acc [16];
            pop_n[1] = 0;
            for (int k = 0; k < 16; k++) send(1, 1'b0, 10'(100 + k), 64'd0, 8'h00, acc[k]);
            wait_cycles(8);
            chk("stream_rsp_count", 64'(pop_n[1]), 64'd16);
            for (int k = 0; k < 16; k++) begin
                chk("stream_latency", 64'(pop_cyc[1][k]), 64'(acc[k] + 3));
                chk("stream_data", pop_dat[1][k], init_word(100 + k));
            end
        end

        // Reset with two reads in flight and one buffered response
        rsp_ready[1] = 1'b0;
        send(1, 1'b0, 10'd20, 64'd0, 8'h00, t0);
        wait_cycles(3);
        @(negedge clk);
        chk("mid_buffered", 64'(rsp_valid[1]), 64'd1);
        step();
        send(1, 1'b0, 10'd21, 64'd0, 8'h00, t1);
        send(1, 1'b0, 10'd22, 64'd0, 8'h00, t2);
        rst = 1'b1;
        rsp_ready[1] = 1'b1;
        step();
        rst = 1'b0;
        pop_n[1] = 0;
        @(negedge clk);
        chk("mid_first_ready", 64'(req_ready[1]), 64'd1);
        chk("mid_valid_cleared", 64'(rsp_valid[1]), 64'd0);
        step();
        repeat (5) begin
            @(negedge clk);
            chk("mid_no_stale", 64'(rsp_valid[1]), 64'd0);
            step();
        end
        chk("mid_stale_count", 64'(pop_n[1]), 64'd0);
        send(1, 1'b0, 10'd7, 64'd0, 8'h00, t3);
        wait_cycles(6);
        chk("mid_post_count", 64'(pop_n[1]), 64'd1);
        chk("mid_post_cycle", 64'(pop_cyc[1][0]), 64'(t3 + 3));
        chk("mid_post_data", pop_dat[1][0], init_word(7));

        // Random traffic on a small address window, both configurations
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                req_valid[i] = 1'($urandom % 2);
                req_we[i]    = 1'($urandom % 2);
                req_addr[i]  = 10'($urandom % 16);
                req_wdata[i] = {$urandom, $urandom};
                req_be[i]    = 8'($urandom);
                rsp_ready[i] = ($urandom % 4) != 0;
            end
            step();
        end
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            rsp_ready[i] = 1'b1;
        end
        wait_cycles(10);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("drain_rsp_valid", 64'(rsp_valid[i]), 64'd0);
            chk("drain_outstanding", 64'(exp_tail[i] - exp_head[i]), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
